// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   OP_*       2-bit operation encodings driven on muldiv_unit.op
//   state_t    controller states (IDLE, RUN, FIX)
//   is_signed  op selects a signed mode (MULT/DIV)
//   is_div     op selects a divide (DIVU/DIV)
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational correction of the unsigned magnitude result
// into the architectural HI/LO values.
//   acc      in  2*WIDTH  final accumulator: product, or {remainder, quotient}
//   div_op   in  1        result comes from a divide
//   neg_res  in  1        negate product / quotient
//   neg_rem  in  1        negate remainder (dividend was negative)
//   dz       in  1        divisor was zero: quotient forced to all ones
//   res_hi   out WIDTH    value to load into HI
//   res_lo   out WIDTH    value to load into LO
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               div_op,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               dz,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (div_op) begin
      res_hi = rem;
      // A zero divisor yields an all-ones quotient magnitude; pin it so the
      // signed sign rule cannot turn it into something else.
      res_lo = dz ? '1 : quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// One shift-add (multiply) or restoring trial subtract (divide) per cycle,
// WIDTH cycles in RUN, one FIX cycle for sign correction, result written on
// the FIX->IDLE edge.
//   clk, rst        clock, synchronous active-high reset
//   start, op       launch MULTU/MULT/DIVU/DIV (taken only when idle)
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   flush           abort in-flight op, cancels a same-cycle start
//   hi_we, lo_we    MTHI/MTLO enables (honoured only when idle), data wdata
//   busy            op in flight
//   done, div_zero  one-cycle completion pulse and divide-by-zero flag
//   hi, lo          HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;     // {partial product hi, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_b;  // multiplicand or divisor magnitude
  logic               div_op;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  logic               sg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign sg    = is_signed(op);
  assign mag_a = (sg && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b = (sg && src_b[WIDTH-1]) ? -src_b : src_b;
  assign busy  = (state != IDLE);

  // One iteration step. The extra top bit carries the add-out on multiply
  // and the borrow of the trial subtract on divide.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : '0)};
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd_b};
    if (!div_op)
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .acc     (acc),
    .div_op  (div_op),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .dz      (dz),
    .res_hi  (fix_hi),
    .res_lo  (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd_b   <= '0;
      div_op   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            state   <= RUN;
            cnt     <= '0;
            acc     <= {{WIDTH{1'b0}}, mag_a};
            opnd_b  <= mag_b;
            div_op  <= is_div(op);
            neg_res <= sg & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem <= sg & src_a[WIDTH-1];
            dz      <= is_div(op) && (src_b == '0);
          end
          RUN: begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            state    <= IDLE;
            hi       <= fix_hi;
            lo       <= fix_lo;
            done     <= 1'b1;
            div_zero <= dz;
          end
          default: state <= IDLE;
        endcase
      end
      // MTHI/MTLO only land while idle; FIX never coincides with IDLE, so
      // a same-cycle start simply gets overwritten later by its result.
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} from plain arithmetic on the operand values.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      OP_MULTU: return ua * ub;
      OP_MULT:  return 64'(sa * sb);
      OP_DIVU:  begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drive start for one cycle from the current negedge (cycle 0); returns at cycle 1.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at cycle n0 of an op; expects done exactly at cycle 34.
  task automatic wait_done(input string tag, input int n0, input logic [31:0] eh,
                           input logic [31:0] el, input logic ez, input bit tail);
    int   n = n0;
    logic busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, ".cycle"}, 64'(n), 64'd34);
    chk({tag, ".busy_run"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, ".busy_done"}, {63'b0, busy}, 64'd0);
    chk({tag, ".hi"}, {32'b0, hi}, {32'b0, eh});
    chk({tag, ".lo"}, {32'b0, lo}, {32'b0, el});
    chk({tag, ".div_zero"}, {63'b0, div_zero}, {63'b0, ez});
    if (tail) begin
      @(negedge clk);
      chk({tag, ".pulse"}, {62'b0, done, div_zero}, 64'd0);
    end
  endtask

  task automatic no_done(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk({tag, ".no_done"}, {63'b0, seen}, 64'd0);
  endtask

  logic [63:0] exp_v;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", {63'b0, busy}, 64'd0);
    chk("rst.done", {63'b0, done}, 64'd0);
    chk("rst.div_zero", {63'b0, div_zero}, 64'd0);
    chk("rst.hi", {32'b0, hi}, 64'd0);
    chk("rst.lo", {32'b0, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MULTU with back-to-back DIVU issued in the done cycle
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done("b2b_divu", 1, 32'd2, 32'd14, 1'b0, 1'b1);

    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1, 32'h0, 32'h8000_0000, 1'b0, 1'b1);

    issue(OP_DIVU, 32'd10, 32'd0);
    wait_done("divu_zero", 1, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // flush at cycle 10 of a DIVU: hi/lo keep the div-by-zero result
    issue(OP_DIVU, 32'd12345, 32'd11);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy", {63'b0, busy}, 64'd0);
    chk("flush.hi", {32'b0, hi}, 64'h0000_000A);
    chk("flush.lo", {32'b0, lo}, 64'hFFFF_FFFF);
    no_done("flush", 40);

    // flush together with start in IDLE cancels the start
    start = 1'b1; flush = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start.busy", {63'b0, busy}, 64'd0);
    no_done("flush_start", 40);

    // start while busy at cycle 5 is ignored
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd99; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 6, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
    no_done("busy_start_after", 5);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {32'b0, hi}, 64'h1234);
    lo_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", {32'b0, lo}, 64'h5678);

    // MTHI while busy is dropped
    issue(OP_MULTU, 32'd7, 32'd6);
    repeat (2) @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_busy.hi", {32'b0, hi}, 64'h1234);
    wait_done("mthi_busy", 4, 32'd0, 32'd42, 1'b0, 1'b1);

    // same-cycle start and MTHI: write lands, result overwrites later
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    issue(OP_MULTU, 32'd3, 32'd3);
    hi_we = 1'b0;
    chk("mthi_start.hi", {32'b0, hi}, 64'hABCD);
    wait_done("mthi_start", 1, 32'd0, 32'd9, 1'b0, 1'b1);

    // reset at cycle 10
    issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.hi", {32'b0, hi}, 64'd0);
    chk("rst_mid.lo", {32'b0, lo}, 64'd0);
    chk("rst_mid.busy", {63'b0, busy}, 64'd0);
    no_done("rst_mid", 40);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = 32'($urandom_range(1, 9));
      if (i % 6 == 1) rb = -rb;
      if (i % 5 == 2) ra = 32'($urandom_range(0, 100));
      if (i % 7 == 3) ra = -ra;
      if (ro[1] && rb == 0) rb = 32'd1;
      exp_v = model(ro, ra, rb);
      issue(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d", i, ro), 1, exp_v[63:32], exp_v[31:0], 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
